data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
- REQ-001 SHALL use one clock and a synchronous, active-high reset: `Clock` (input, 1, rising-edge clock) and `Clear` (input, 1, synchronous active-high reset).
- REQ-002 SHALL have bus-driver inputs, all 1 bit: `PCout`, `ZHighout`, `Zlowout`, `MDRout`, `R2out`, `R3out`, `R4out`, `R5out`, `R6out`, `R7out`. Each, when high, selects its source onto the internal 32-bit bus.
- REQ-003 SHALL have register-load inputs, all 1 bit: `MARin`, `PCin`, `MDRin`, `IRin`, `Yin`, `R1in` through `R15in`, `HIin`, `LOin`, `ZHighIn`, `ZLowIn`, `Cin`.
- REQ-004 SHALL have these further inputs:
  - `IncPC` (1): PC increment.
  - `Read` (1): MDR source select.
  - `DIV` (5): ALU opcode.
  - `Mdatain` (32): memory data.
- REQ-005 SHALL take ports positionally in this order: `PCout`, `ZHighout`, `Zlowout`, `MDRout`, `R2out`–`R7out`, `MARin`, `PCin`, `MDRin`, `IRin`, `Yin`, `IncPC`, `Read`, `DIV`, `R1in`–`R15in`, `HIin`, `LOin`, `ZHighIn`, `ZLowIn`, `Cin`, `Clock`, `Clear`, `Mdatain`.
- REQ-006 SHALL have no output ports; benches probe these internal 32-bit registers hierarchically: `BusMuxOut`, `R1`–`R15`, `PC`, `IR`, `MAR`, `MDR`, `Y`, `ZHigh`, `ZLow`, `HI`, `LO`.

Function
- REQ-007 SHALL drive `BusMuxOut` combinationally in this fixed priority order: `MDRout` > `PCout` > `Zlowout` > `ZHighout` > `R2out` > … > `R7out`. With no driver asserted, the bus is 0.
- REQ-008 SHALL load each register from `BusMuxOut` on the rising edge when its `*in` is high: `R1`–`R15`, `PC`, `IR`, `MAR`, `Y`, `HI`, `LO`. Otherwise each register holds its value.
- REQ-009 SHALL load `MDR` when `MDRin` is high, from `Mdatain` if `Read` is 1, else from `BusMuxOut`.
- REQ-010 SHALL load `PC <= PC+1` on the edge when `IncPC` is high.
  - `IncPC` overrides `PCin`.
  - PC wraps from `0xFFFFFFFF` to 0.
- REQ-011 SHALL compute a 64-bit ALU result combinationally, with A = `Y`, B = `BusMuxOut` and carry-in = `Cin`.
- REQ-012 SHALL decode the ALU opcode `DIV` as follows (32-bit results go in the low word, high word 0 unless stated):

  | Opcode | Operation |
  |---|---|
  | 00000 | ADD: A+B+Cin |
  | 00001 | SUB: A−B |
  | 00010 | AND |
  | 00011 | OR |
  | 00100 | SHR: logical right shift |
  | 00101 | SHRA: arithmetic right shift |
  | 00110 | SHL: left shift |
  | 00111 | ROR: rotate right |
  | 01000 | ROL: rotate left |
  | 01001 | NEG: −B |
  | 01010 | NOT: ~B |
  | 01111 | MUL: signed, full 64-bit product in high:low |
  | 10000 | DIV: signed; quotient in low word, remainder in high word |
  | other | result 0 |

- REQ-013 SHALL use `B[4:0]` as the shift/rotate amount.
- REQ-014 SHALL use truncating signed division, with the remainder taking the sign of the dividend.
  - Division by zero gives quotient `0xFFFFFFFF` and remainder = A.
- REQ-015 SHALL load `ZLow <= result[31:0]` when `ZLowIn` is high and `ZHigh <= result[63:32]` when `ZHighIn` is high. The two loads are independent.
- REQ-016 SHALL add one clock of latency from operands to Z. Operands are valid in the cycle the load is asserted, and Z is readable on the bus the following cycle.
- REQ-017 SHALL update all registers loaded in the same cycle, each from pre-edge values.

Reset
- REQ-018 SHALL clear every internal register to 0 at a rising edge with `Clear` high.
- REQ-019 SHALL give `Clear` priority over all loads and `IncPC`.
- REQ-020 SHALL discard an operation in progress when `Clear` is asserted mid-operation. No pending state survives.

Configuration
- REQ-021 SHALL implement opcode 10000 per REQ-012/REQ-014 when macro `DATA_PATH_DIV_EN` is defined.
- REQ-022 SHALL, without `DATA_PATH_DIV_EN`, omit the divider hardware, and opcode 10000 yields result 0.

Verification
- REQ-023 Load `R4`=20, `R5`=5 and `R1`=0x18 via `Mdatain`→`MDR`→bus. Then `R4out`/`Yin`, then `R5out`/`DIV`=10000/`ZLowIn`, then `Zlowout`/`R1in` → `ZLow`=4 and `R1`=4.
- REQ-024 `DIV` with `Y`=−7, bus=2, both `ZLowIn` and `ZHighIn` high → `ZLow`=0xFFFFFFFD (−3) and `ZHigh`=0xFFFFFFFF (−1). Divide by 0 → `ZLow`=0xFFFFFFFF and `ZHigh`=A.
- REQ-025 MUL with `Y`=0x10000, bus=0x10000 → `ZHigh`=1 and `ZLow`=0. ADD with `Y`=0xFFFFFFFF, bus=1, `Cin`=0 → `ZLow`=0.
- REQ-026 `PC`=0xFFFFFFFF with `IncPC`, and `PCin` also high → `PC`=0. `PCout`, `MARin` and `MDRout` all high → `MAR` gets `MDR` (bus priority).
- REQ-027 `Clear` asserted alongside `R1in`, `MDRin` and `ZLowIn` → all registers 0 after the edge.

Source files
------------

// File: rtl/data_path.sv
// Single-bus register file + ALU datapath; Z loads one edge after operands; no flow control (every load completes on its edge).
// Define DATA_PATH_DIV_EN to build the signed divider, otherwise opcode 10000 yields 0.
module data_path (
  input  logic        PCout,
  input  logic        ZHighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  DIV,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Cin,
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Mdatain
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_NOT  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
`ifdef DATA_PATH_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

  logic [31:0] BusMuxOut;
  logic [31:0] PC, IR, MAR, MDR, Y, ZHigh, ZLow, HI, LO;
  logic [31:0] R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
  logic [31:0] rf [1:15];
  logic [15:1] r_in;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in};

  assign R1  = rf[1];
  assign R2  = rf[2];
  assign R3  = rf[3];
  assign R4  = rf[4];
  assign R5  = rf[5];
  assign R6  = rf[6];
  assign R7  = rf[7];
  assign R8  = rf[8];
  assign R9  = rf[9];
  assign R10 = rf[10];
  assign R11 = rf[11];
  assign R12 = rf[12];
  assign R13 = rf[13];
  assign R14 = rf[14];
  assign R15 = rf[15];

  // Fixed-priority bus: a lower source never corrupts a higher one driven in the same cycle.
  always_comb begin
    BusMuxOut = '0;
    if (MDRout)        BusMuxOut = MDR;
    else if (PCout)    BusMuxOut = PC;
    else if (Zlowout)  BusMuxOut = ZLow;
    else if (ZHighout) BusMuxOut = ZHigh;
    else if (R2out)    BusMuxOut = R2;
    else if (R3out)    BusMuxOut = R3;
    else if (R4out)    BusMuxOut = R4;
    else if (R5out)    BusMuxOut = R5;
    else if (R6out)    BusMuxOut = R6;
    else if (R7out)    BusMuxOut = R7;
  end

  logic [31:0]        alu_a, alu_b;
  logic [4:0]         shamt;
  logic [63:0]        a_dbl;
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic [63:0]        result;

  assign alu_a = Y;
  assign alu_b = BusMuxOut;
  assign shamt = alu_b[4:0];
  assign a_dbl = {alu_a, alu_a};
  assign mul_a = {{32{alu_a[31]}}, alu_a};
  assign mul_b = {{32{alu_b[31]}}, alu_b};
  assign mul_p = mul_a * mul_b;

`ifdef DATA_PATH_DIV_EN
  logic [31:0] div_quo, div_rem;

  // Most-negative / -1 overflows; pin it to the wrapped quotient so it does not depend on the simulator.
  always_comb begin
    div_quo = '0;
    div_rem = '0;
    if (alu_b == 32'd0) begin
      div_quo = 32'hFFFF_FFFF;
      div_rem = alu_a;
    end else if (alu_a == 32'h8000_0000 && alu_b == 32'hFFFF_FFFF) begin
      div_quo = alu_a;
      div_rem = '0;
    end else begin
      div_quo = $signed(alu_a) / $signed(alu_b);
      div_rem = $signed(alu_a) % $signed(alu_b);
    end
  end
`endif

  always_comb begin
    result = '0;
    case (DIV)
      OP_ADD:  result[31:0] = alu_a + alu_b + {31'd0, Cin};
      OP_SUB:  result[31:0] = alu_a - alu_b;
      OP_AND:  result[31:0] = alu_a & alu_b;
      OP_OR:   result[31:0] = alu_a | alu_b;
      OP_SHR:  result[31:0] = alu_a >> shamt;
      OP_SHRA: result[31:0] = $signed(alu_a) >>> shamt;
      OP_SHL:  result[31:0] = alu_a << shamt;
      OP_ROR:  result[31:0] = 32'(a_dbl >> shamt);
      OP_ROL:  result[31:0] = 32'((a_dbl << shamt) >> 32);
      OP_NEG:  result[31:0] = 32'd0 - alu_b;
      OP_NOT:  result[31:0] = ~alu_b;
      OP_MUL:  result       = mul_p;
`ifdef DATA_PATH_DIV_EN
      OP_DIV:  result       = {div_rem, div_quo};
`endif
      default: result       = '0;
    endcase
  end

  // Every register samples pre-edge values, so same-cycle loads never see each other.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      for (int i = 1; i <= 15; i++) rf[i] <= '0;
      PC    <= '0;
      IR    <= '0;
      MAR   <= '0;
      MDR   <= '0;
      Y     <= '0;
      ZHigh <= '0;
      ZLow  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      for (int i = 1; i <= 15; i++) begin
        if (r_in[i]) rf[i] <= BusMuxOut;
      end
      if (IncPC)     PC <= PC + 32'd1;
      else if (PCin) PC <= BusMuxOut;
      if (IRin)      IR <= BusMuxOut;
      if (MARin)     MAR <= BusMuxOut;
      if (MDRin)     MDR <= Read ? Mdatain : BusMuxOut;
      if (Yin)       Y <= BusMuxOut;
      if (HIin)      HI <= BusMuxOut;
      if (LOin)      LO <= BusMuxOut;
      if (ZLowIn)    ZLow <= result[31:0];
      if (ZHighIn)   ZHigh <= result[63:32];
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: stimulus pushes expected register values into a queue, a negedge monitor pops and compares.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, ZHighout, Zlowout, MDRout;
  logic [7:2]  rout;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0]  DIV;
  logic [15:1] rin;
  logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
  logic [31:0] Mdatain;

  always #5 Clock = ~Clock;

  data_path dut (
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]),
    .R6out(rout[6]), .R7out(rout[7]),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .DIV(DIV),
    .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
    .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]),
    .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
    .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain)
  );

  localparam int S_BUS = 0, S_PC = 16, S_IR = 17, S_MAR = 18, S_MDR = 19,
                 S_Y = 20, S_ZH = 21, S_ZL = 22, S_HI = 23, S_LO = 24;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_BUS: return dut.BusMuxOut;
      1:  return dut.R1;   2:  return dut.R2;   3:  return dut.R3;
      4:  return dut.R4;   5:  return dut.R5;   6:  return dut.R6;
      7:  return dut.R7;   8:  return dut.R8;   9:  return dut.R9;
      10: return dut.R10;  11: return dut.R11;  12: return dut.R12;
      13: return dut.R13;  14: return dut.R14;  15: return dut.R15;
      S_PC:  return dut.PC;
      S_IR:  return dut.IR;
      S_MAR: return dut.MAR;
      S_MDR: return dut.MDR;
      S_Y:   return dut.Y;
      S_ZH:  return dut.ZHigh;
      S_ZL:  return dut.ZLow;
      S_HI:  return dut.HI;
      S_LO:  return dut.LO;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  always @(negedge Clock) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      act = probe(e.sel);
      total_cnt++;
      if (act === e.val) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
    end
  end

  task automatic idle();
    PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; rout = '0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
    DIV = '0; rin = '0; HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
    Clear = 0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; rin[idx] = 1;
    tick();
  endtask

  task automatic alu(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] op, input logic cin,
                     input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    load_reg(2, a);
    load_reg(3, b);
    rout[2] = 1; Yin = 1;
    tick();
    rout[3] = 1; DIV = op; Cin = cin; ZLowIn = 1; ZHighIn = 1;
    tick();
    push_exp({name, "_lo"}, S_ZL, exp_lo);
    push_exp({name, "_hi"}, S_ZH, exp_hi);
  endtask

  logic div_en;

  initial begin
`ifdef DATA_PATH_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    idle();
    Clear = 1;
    tick();
    push_exp("rst_pc", S_PC, 32'd0);
    push_exp("rst_r1", 1, 32'd0);
    push_exp("rst_mdr", S_MDR, 32'd0);
    push_exp("rst_zl", S_ZL, 32'd0);
    push_exp("rst_bus_idle", S_BUS, 32'd0);

    load_reg(4, 32'd20);
    load_reg(5, 32'd5);
    load_reg(1, 32'h18);
    push_exp("ld_r4", 4, 32'd20);
    push_exp("ld_r5", 5, 32'd5);
    push_exp("ld_r1", 1, 32'h18);
    rout[4] = 1; Yin = 1;
    tick();
    push_exp("div_y", S_Y, 32'd20);
    rout[5] = 1; DIV = 5'b10000; ZLowIn = 1;
    push_exp("div_bus_r5", S_BUS, 32'd5);
    tick();
    push_exp("div20_5_zl", S_ZL, div_en ? 32'd4 : 32'd0);
    Zlowout = 1; rin[1] = 1;
    tick();
    push_exp("div20_5_r1", 1, div_en ? 32'd4 : 32'd0);

    alu("div_m7_2", 32'hFFFF_FFF9, 32'd2, 5'b10000, 0,
        div_en ? 32'hFFFF_FFFD : 32'd0, div_en ? 32'hFFFF_FFFF : 32'd0);
    alu("div_by0", 32'hFFFF_FFF9, 32'd0, 5'b10000, 0,
        div_en ? 32'hFFFF_FFFF : 32'd0, div_en ? 32'hFFFF_FFF9 : 32'd0);
    alu("mul_big", 32'h0001_0000, 32'h0001_0000, 5'b01111, 0, 32'd0, 32'd1);
    alu("mul_neg", 32'hFFFF_FFFD, 32'd5, 5'b01111, 0, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
    alu("add_wrap", 32'hFFFF_FFFF, 32'd1, 5'b00000, 0, 32'd0, 32'd0);
    alu("add_cin", 32'd5, 32'd7, 5'b00000, 1, 32'd13, 32'd0);
    alu("sub", 32'd5, 32'd7, 5'b00001, 0, 32'hFFFF_FFFE, 32'd0);
    alu("and", 32'hF0F0_1234, 32'h0FF0_00FF, 5'b00010, 0, 32'h00F0_0034, 32'd0);
    alu("shr_amt5", 32'h8000_0000, 32'h21, 5'b00100, 0, 32'h4000_0000, 32'd0);
    alu("shra", 32'h8000_0000, 32'd4, 5'b00101, 0, 32'hF800_0000, 32'd0);
    alu("shl", 32'd1, 32'd31, 5'b00110, 0, 32'h8000_0000, 32'd0);
    alu("ror", 32'h1234_5678, 32'd8, 5'b00111, 0, 32'h7812_3456, 32'd0);
    alu("rol", 32'h1234_5678, 32'd4, 5'b01000, 0, 32'h2345_6781, 32'd0);
    alu("neg", 32'd0, 32'd1, 5'b01001, 0, 32'hFFFF_FFFF, 32'd0);
    alu("not", 32'd0, 32'h0000_FFFF, 5'b01010, 0, 32'hFFFF_0000, 32'd0);
    alu("bad_op", 32'd3, 32'd4, 5'b01011, 0, 32'd0, 32'd0);

    // PC wrap with PCin also asserted: increment must win.
    Mdatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; PCin = 1;
    tick();
    push_exp("pc_load", S_PC, 32'hFFFF_FFFF);
    Mdatain = 32'h1234_0000; Read = 1; MDRin = 1;
    tick();
    IncPC = 1; PCin = 1; MDRout = 1;
    tick();
    push_exp("pc_wrap", S_PC, 32'd0);

    Mdatain = 32'hA5A5_A5A5; Read = 1; MDRin = 1; IncPC = 1;
    tick();
    push_exp("pc_inc", S_PC, 32'd1);
    PCout = 1; MARin = 1; MDRout = 1;
    push_exp("bus_prio_mdr", S_BUS, 32'hA5A5_A5A5);
    tick();
    push_exp("mar_prio", S_MAR, 32'hA5A5_A5A5);
    PCout = 1; Zlowout = 1; rout[7] = 1; HIin = 1; LOin = 1; IRin = 1;
    push_exp("bus_prio_pc", S_BUS, 32'd1);
    tick();
    push_exp("hi_pc", S_HI, 32'd1);
    push_exp("ir_pc", S_IR, 32'd1);
    // MDR reload from its own bus value, Y from the same pre-edge bus.
    MDRout = 1; MDRin = 1; Read = 0; Yin = 1;
    tick();
    push_exp("mdr_self", S_MDR, 32'hA5A5_A5A5);
    push_exp("y_same_edge", S_Y, 32'hA5A5_A5A5);

    Clear = 1; rin[1] = 1; MDRin = 1; Read = 1; Mdatain = 32'h5555_AAAA;
    ZLowIn = 1; ZHighIn = 1; MDRout = 1; Yin = 1; IncPC = 1; DIV = 5'b01010;
    tick();
    total_cnt++;
    if (dut.PC === 32'd0) pass_cnt++;
    else $display("FAIL clr_pc_direct: got 0x%08h expected 0x00000000", dut.PC);
    total_cnt++;
    if (dut.R1 === 32'd0) pass_cnt++;
    else $display("FAIL clr_r1_direct: got 0x%08h expected 0x00000000", dut.R1);
    total_cnt++;
    if (dut.MDR === 32'd0) pass_cnt++;
    else $display("FAIL clr_mdr_direct: got 0x%08h expected 0x00000000", dut.MDR);
    push_exp("clr_r1", 1, 32'd0);
    push_exp("clr_r4", 4, 32'd0);
    push_exp("clr_mdr", S_MDR, 32'd0);
    push_exp("clr_zl", S_ZL, 32'd0);
    push_exp("clr_zh", S_ZH, 32'd0);
    push_exp("clr_pc", S_PC, 32'd0);
    push_exp("clr_mar", S_MAR, 32'd0);
    push_exp("clr_y", S_Y, 32'd0);
    push_exp("clr_hi", S_HI, 32'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge Clock);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total_cnt++;
      $display("FAIL %s: got no sample expected 0x%08h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
